// File: rtl/frame_check.sv
// frame_check: UART receive frame-integrity checker (data bits, optional parity, 1..2 stop bits).
// Define FRAME_CHECK_ERR_CNT_EN to build the saturating parity/stop error counters and cnt_clr.
module frame_check #(
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BITS     = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     par_en,
  input  logic                     par_type,
  input  logic                     cnt_clr,
  output logic [DATA_WIDTH-1:0]    p_data,
  output logic                     data_valid,
  output logic                     par_error,
  output logic                     stop_error,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] stop_err_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [3:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_par_fail;
  logic                  r_stop_fail;
  logic                  r_data_valid;
  logic                  r_par_error;
  logic                  r_stop_error;
  logic                  r_busy;
  logic                  w_data_last;
  logic                  w_stop_last;
  logic                  w_stop_fail;
  logic                  w_frame_ok;

  function automatic logic f_even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  assign w_data_last = (r_idx == DATA_LAST);
  assign w_stop_last = (r_idx == STOP_LAST);
  assign w_stop_fail = r_stop_fail | ~bit_in;
  assign w_frame_ok  = ~r_par_fail & ~w_stop_fail;

  // Next-state selection; a frame_start from any state restarts the frame.
  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = S_DATA;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_IDLE;
        S_DATA: begin
          if (bit_valid && w_data_last) begin
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_PARITY: begin
          if (bit_valid) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_PARITY;
          end
        end
        S_STOP: begin
          if (bit_valid && w_stop_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_STOP;
          end
        end
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame sequencing; results register on the final stop bit so they are visible during DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 4'd0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_par_en     <= 1'b0;
      r_par_type   <= 1'b0;
      r_par_fail   <= 1'b0;
      r_stop_fail  <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_error  <= 1'b0;
      r_stop_error <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_data_valid <= 1'b0;
      if (frame_start) begin
        r_idx        <= 4'd0;
        r_par_en     <= par_en;
        r_par_type   <= par_type;
        r_par_fail   <= 1'b0;
        r_stop_fail  <= 1'b0;
        r_par_error  <= 1'b0;
        r_stop_error <= 1'b0;
      end else if (bit_valid) begin
        case (r_state)
          S_DATA: begin
            // Shifting in at the MSB leaves the first-received bit at index 0.
            r_shift <= {bit_in, r_shift[DATA_WIDTH-1:1]};
            r_idx   <= w_data_last ? 4'd0 : r_idx + 4'd1;
          end
          S_PARITY: r_par_fail <= (bit_in != (f_even_parity(r_shift) ^ r_par_type));
          S_STOP: begin
            r_stop_fail <= w_stop_fail;
            r_idx       <= r_idx + 4'd1;
            if (w_stop_last) begin
              r_par_error  <= r_par_fail;
              r_stop_error <= w_stop_fail;
              if (w_frame_ok) begin
                r_p_data     <= r_shift;
                r_data_valid <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign p_data     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_error  = r_par_error;
  assign stop_error = r_stop_error;
  assign busy       = r_busy;

`ifdef FRAME_CHECK_ERR_CNT_EN
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  logic [ERR_CNT_WIDTH-1:0] r_par_cnt;
  logic [ERR_CNT_WIDTH-1:0] r_stop_cnt;
  logic                     w_cnt_tick;

  assign w_cnt_tick = (r_state == S_DONE) & ~frame_start;

  // Saturating error counters; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_cnt  <= '0;
      r_stop_cnt <= '0;
    end else if (cnt_clr) begin
      r_par_cnt  <= '0;
      r_stop_cnt <= '0;
    end else if (w_cnt_tick) begin
      if (r_par_error && (r_par_cnt != '1)) begin
        r_par_cnt <= r_par_cnt + CNT_ONE;
      end
      if (r_stop_error && (r_stop_cnt != '1)) begin
        r_stop_cnt <= r_stop_cnt + CNT_ONE;
      end
    end
  end

  assign par_err_cnt  = r_par_cnt;
  assign stop_err_cnt = r_stop_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign par_err_cnt      = '0;
  assign stop_err_cnt     = '0;
`endif

endmodule

// File: tb/tb_frame_check.sv
// Bench for frame_check: two configurations (1 stop bit / 8-bit counters, 2 stop bits / 2-bit counters)
// share one stimulus stream and are compared every cycle against a frame-level reference model.
module tb_frame_check;

`ifdef FRAME_CHECK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic par_en = 1'b0;
  logic par_type = 1'b0;
  logic cnt_clr = 1'b0;

  logic [7:0] a_p_data, b_p_data;
  logic       a_dv, a_pe, a_se, a_busy;
  logic       b_dv, b_pe, b_se, b_busy;
  logic [7:0] a_pc, a_sc;
  logic [1:0] b_pc, b_sc;

  frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in), .bit_valid(bit_valid),
    .par_en(par_en), .par_type(par_type), .cnt_clr(cnt_clr), .p_data(a_p_data), .data_valid(a_dv),
    .par_error(a_pe), .stop_error(a_se), .busy(a_busy), .par_err_cnt(a_pc), .stop_err_cnt(a_sc));

  frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in), .bit_valid(bit_valid),
    .par_en(par_en), .par_type(par_type), .cnt_clr(cnt_clr), .p_data(b_p_data), .data_valid(b_dv),
    .par_error(b_pe), .stop_error(b_se), .busy(b_busy), .par_err_cnt(b_pc), .stop_err_cnt(b_sc));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  int dv_a = 0;
  int dv_b = 0;

  // Reference model: one entry per instance, tracking the frame as a list of received bits.
  int         mdw[2] = '{8, 8};
  int         msb[2] = '{1, 2};
  int         mcw[2] = '{8, 2};
  logic [7:0] e_pdata[2];
  bit         e_dv[2], e_pe[2], e_se[2], e_busy[2];
  bit         in_frame[2], done_c[2], lpen[2], lpty[2];
  int         e_pc[2], e_sc[2], nb[2];
  logic [15:0] fb[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int m);
    int maxc;
    int total;
    logic [7:0] d;
    bit x, perr, serr;
    if (!rst) begin
      in_frame[m] = 1'b0; done_c[m] = 1'b0; nb[m] = 0; fb[m] = '0;
      e_pdata[m] = 8'h00; e_dv[m] = 1'b0; e_pe[m] = 1'b0; e_se[m] = 1'b0;
      e_busy[m] = 1'b0; e_pc[m] = 0; e_sc[m] = 0;
    end else begin
      maxc = (1 << mcw[m]) - 1;
      if (done_c[m] && !frame_start) begin
        if (e_pe[m] && e_pc[m] < maxc) e_pc[m] = e_pc[m] + 1;
        if (e_se[m] && e_sc[m] < maxc) e_sc[m] = e_sc[m] + 1;
      end
      if (cnt_clr || !CNT_EN) begin
        e_pc[m] = 0;
        e_sc[m] = 0;
      end
      e_dv[m] = 1'b0;
      if (frame_start) begin
        in_frame[m] = 1'b1; done_c[m] = 1'b0; nb[m] = 0; fb[m] = '0;
        lpen[m] = par_en; lpty[m] = par_type; e_pe[m] = 1'b0; e_se[m] = 1'b0;
      end else if (done_c[m]) begin
        done_c[m] = 1'b0;
      end else if (in_frame[m] && bit_valid) begin
        fb[m][nb[m]] = bit_in;
        nb[m] = nb[m] + 1;
        total = mdw[m] + int'(lpen[m]) + msb[m];
        if (nb[m] == total) begin
          d = 8'h00; x = 1'b0;
          for (int i = 0; i < mdw[m]; i++) begin
            d[i] = fb[m][i];
            x = x ^ fb[m][i];
          end
          perr = lpen[m] && (fb[m][mdw[m]] != (x ^ lpty[m]));
          serr = 1'b0;
          for (int j = 0; j < msb[m]; j++) begin
            if (fb[m][mdw[m] + int'(lpen[m]) + j] == 1'b0) serr = 1'b1;
          end
          e_pe[m] = perr;
          e_se[m] = serr;
          if (!perr && !serr) begin
            e_pdata[m] = d;
            e_dv[m] = 1'b1;
          end
          in_frame[m] = 1'b0;
          done_c[m] = 1'b1;
        end
      end
      e_busy[m] = in_frame[m] || done_c[m];
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (a_dv) dv_a = dv_a + 1;
    if (b_dv) dv_b = dv_b + 1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a.p_data", 32'(a_p_data), 32'(e_pdata[0]));
      chk("a.data_valid", 32'(a_dv), 32'(e_dv[0]));
      chk("a.par_error", 32'(a_pe), 32'(e_pe[0]));
      chk("a.stop_error", 32'(a_se), 32'(e_se[0]));
      chk("a.busy", 32'(a_busy), 32'(e_busy[0]));
      chk("a.par_err_cnt", 32'(a_pc), e_pc[0]);
      chk("a.stop_err_cnt", 32'(a_sc), e_sc[0]);
      chk("b.p_data", 32'(b_p_data), 32'(e_pdata[1]));
      chk("b.data_valid", 32'(b_dv), 32'(e_dv[1]));
      chk("b.par_error", 32'(b_pe), 32'(e_pe[1]));
      chk("b.stop_error", 32'(b_se), 32'(e_se[1]));
      chk("b.busy", 32'(b_busy), 32'(e_busy[1]));
      chk("b.par_err_cnt", 32'(b_pc), e_pc[1]);
      chk("b.stop_err_cnt", 32'(b_sc), e_sc[1]);
    end
  end

  task automatic cyc(input bit fs, input bit bv, input bit b, input bit clr, input bit pen, input bit pty);
    @(negedge clk);
    frame_start = fs;
    bit_valid   = bv;
    bit_in      = b;
    cnt_clr     = clr;
    if (fs) begin
      par_en   = pen;
      par_type = pty;
    end else begin
      par_en   = 1'($urandom);
      par_type = 1'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pty, input bit pbit,
                            input logic [1:0] stp, input int maxgap, input bit fsbv, input bit clr_after);
    cyc(1'b1, fsbv, 1'($urandom), 1'b0, pen, pty);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, maxgap));
      cyc(1'b0, 1'b1, d[i], 1'b0, 1'b0, 1'b0);
    end
    if (pen) begin
      idle($urandom_range(0, maxgap));
      cyc(1'b0, 1'b1, pbit, 1'b0, 1'b0, 1'b0);
    end
    for (int j = 0; j < 2; j++) begin
      idle($urandom_range(0, maxgap));
      cyc(1'b0, 1'b1, stp[j], 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, clr_after, 1'b0, 1'b0);
    idle(2);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         pen;
    bit         pty;
    bit         pbit;
    logic [1:0] stp;
    logic [7:0] e_pd;
    bit         e_dv;
    bit         e_pe;
    bit         e_se;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] d;
    bit pen, pty, pbit;
    logic [1:0] stp;

    // Expectations are for the 1-stop-bit instance; stp[0] is its stop bit, stp[1] only matters to u_b.
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 2'b11, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 2'b01, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h81, 1'b0, 1'b0, 1'b0, 2'b10, 8'h5A, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h7E, 1'b1, 1'b0, 1'b0, 2'b11, 8'h7E, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 2'b00, 8'h7E, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{8'hFF, 1'b0, 1'b0, 1'b0, 2'b11, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;
    #1;
    chk("reset.p_data", 32'(a_p_data), 32'h0);
    chk("reset.data_valid", 32'(a_dv), 32'h0);
    chk("reset.flags", 32'({a_pe, a_se}), 32'h0);
    chk("reset.busy", 32'(a_busy), 32'h0);
    chk("reset.counters", 32'({a_pc, a_sc}), 32'h0);

    for (int i = 0; i < 8; i++) begin
      dv_a = 0;
      send_frame(tbl[i].d, tbl[i].pen, tbl[i].pty, tbl[i].pbit, tbl[i].stp, 0, 1'b0, 1'b0);
      #1;
      chk("tbl.dv_count", dv_a, 32'(tbl[i].e_dv));
      chk("tbl.p_data", 32'(a_p_data), 32'(tbl[i].e_pd));
      chk("tbl.par_error", 32'(a_pe), 32'(tbl[i].e_pe));
      chk("tbl.stop_error", 32'(a_se), 32'(tbl[i].e_se));
    end
    chk("tbl.par_err_cnt", 32'(a_pc), CNT_EN ? 32'd2 : 32'd0);
    chk("tbl.stop_err_cnt", 32'(a_sc), CNT_EN ? 32'd2 : 32'd0);

    // Abort after four data bits, then a clean frame.
    dv_a = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'(i & 1), 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0, 1'b0);
    #1;
    chk("abort.dv_count", dv_a, 32'd1);
    chk("abort.p_data", 32'(a_p_data), 32'h3C);
    chk("abort.par_err_cnt", 32'(a_pc), CNT_EN ? 32'd2 : 32'd0);
    chk("abort.stop_err_cnt", 32'(a_sc), CNT_EN ? 32'd2 : 32'd0);

    // Saturation of the 2-bit stop counter, then clear colliding with an increment.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    #1;
    chk("clr.b_stop_err_cnt", 32'(b_sc), 32'd0);
    chk("clr.a_par_err_cnt", 32'(a_pc), 32'd0);
    dv_b = 0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 2'b01, 0, 1'b0, 1'b0);
    #1;
    chk("stop2.stop_error", 32'(b_se), 32'd1);
    chk("stop2.dv_count", dv_b, 32'd0);
    chk("stop2.stop_err_cnt", 32'(b_sc), CNT_EN ? 32'd1 : 32'd0);
    chk("stop2.a_p_data", 32'(a_p_data), 32'h5A);
    for (int i = 0; i < 4; i++) send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 2'b01, 0, 1'b0, 1'b0);
    #1;
    chk("sat.stop_err_cnt", 32'(b_sc), CNT_EN ? 32'd3 : 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 2'b01, 0, 1'b0, 1'b1);
    #1;
    chk("satclr.stop_err_cnt", 32'(b_sc), 32'd0);
    chk("satclr.stop_error", 32'(b_se), 32'd1);

    // Reset in the middle of the data phase.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    frame_start = 1'b0;
    bit_valid = 1'b0;
    #2;
    chk("midrst.p_data", 32'(a_p_data), 32'h0);
    chk("midrst.busy", 32'({a_busy, b_busy}), 32'h0);
    chk("midrst.outputs", 32'({a_dv, a_pe, a_se, b_dv, b_pe, b_se}), 32'h0);
    chk("midrst.counters", 32'({a_pc, a_sc, b_pc, b_sc}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    dv_a = 0;
    dv_b = 0;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0, 1'b0);
    #1;
    chk("postrst.dv_count", dv_a + dv_b, 32'd2);
    chk("postrst.p_data", 32'({a_p_data, b_p_data}), 32'hFFFF);

    // Randomised frames with gaps, aborts, discarded same-cycle bits and counter clears.
    for (int k = 0; k < 250; k++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      pty  = 1'($urandom);
      pbit = (^d) ^ pty ^ ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 7) == 0) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
        for (int i = 0; i < int'($urandom_range(0, 9)); i++)
          cyc(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
      end
      send_frame(d, pen, pty, pbit, stp, 2, 1'($urandom), 1'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 5) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
